hssl_link_ctrl: RTL and testbench
=================================

# hssl_link_ctrl

Bring-up and recovery controller for the HSSL interface. It holds the spiNNlink transceiver path in reset until software enables the link. It then sequences the link through reset, comma sync and the spiNNlink handshake, and gates packet traffic with `stop` until the link is up. On loss of sync, a dropped handshake or a timeout it retries automatically, and it declares permanent failure on a version mismatch or when the retry budget is exhausted.

## Interface
Parameters:
- `RESET_CYCLES`, 16: cycles `link_reset_out` is held in RESET (≥2).
- `SYNC_TIMEOUT`, 65536: maximum cycles in WAIT_SYNC.
- `HS_TIMEOUT`, 262144: maximum cycles in WAIT_HS.
- `LOSS_FILTER`, 4: consecutive cycles of non-zero sync state in UP before the link is declared down (≥1).
- `MAX_RETRIES`, 15: consecutive failed attempts before FAILED; 0 means unlimited.
- `TIMER_BITS`, 20: state timer width; must hold the largest timeout minus 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable_in` in 1: software link enable (level).
- `stop_req_in` in 1: software traffic stop, ORed into `stop_out`.
- `loss_of_sync_state_in` in 2: 00 = sync acquired, 01 = resync, 10 = loss of sync.
- `handshake_complete_in` in 1: spiNNlink handshake done.
- `version_mismatch_in` in 1: peer version incompatible.
- `link_reset_out` out 1: reset to the HSSL interface and transceiver RX path.
- `stop_out` out 1: stop to the frame transmitter.
- `link_up_out` out 1: link usable.
- `fail_out` out 1: link in FAILED.
- `state_out` out 3: current state code.
- `retry_cnt_out` out 8: consecutive failed attempts, saturating.
- `link_drops_out` out 16: total UP→retry events, saturating; cleared only by `reset`.

## Operation
- State codes: IDLE = 0, RESET = 1, WAIT_SYNC = 2, WAIT_HS = 3, UP = 4, FAILED = 5. Codes 6 and 7 are illegal and go to IDLE.
- `enable_in` = 0 in any state forces IDLE on the next edge. This has the highest priority.
- IDLE: `retry_cnt` is cleared. `enable_in` = 1 moves to RESET.
- RESET: exits to WAIT_SYNC when `timer` = RESET_CYCLES−1.
- WAIT_SYNC: sync = 00 moves to WAIT_HS. Otherwise `timer` = SYNC_TIMEOUT−1 triggers a retry.
- WAIT_HS, in priority order:
  - `version_mismatch_in` moves to FAILED.
  - Sync ≠ 00 triggers a retry.
  - `handshake_complete_in` moves to UP.
  - `timer` = HS_TIMEOUT−1 triggers a retry.
- UP:
  - `retry_cnt` is cleared on entry.
  - `loss_cnt` counts consecutive cycles with sync ≠ 00 and clears on sync = 00.
  - `loss_cnt` reaching LOSS_FILTER, or `handshake_complete_in` = 0, triggers a retry and increments `link_drops`.
  - `version_mismatch_in` moves to FAILED.
- Retry: `retry_cnt` increments (saturating at 255). If MAX_RETRIES ≠ 0 and the incremented value ≥ MAX_RETRIES, go to FAILED; otherwise go to RESET.
- FAILED: held until `enable_in` = 0.
- `timer` clears on every state transition and increments otherwise.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- `link_reset_out` = 1 in IDLE, RESET and FAILED.
- `stop_out` = (state ≠ UP) | `stop_req_in`. `stop_req_in` reaches the output one cycle later.
- `link_up_out` = 1 only in UP. `fail_out` = 1 only in FAILED.
- Values on `reset`: state IDLE, `link_reset_out` = 1, `stop_out` = 1, `link_up_out` = 0, `fail_out` = 0, all counters 0.
- Reset asserted mid-operation immediately returns every register to its reset value.
- Timing from enable:
  - `enable_in` rising at edge N puts the block in RESET after edge N.
  - `link_reset_out` then deasserts after RESET_CYCLES cycles.
  - With sync already 00 and the handshake complete, `link_up_out` rises 2 cycles after `link_reset_out` falls.
- Simultaneous events:
  - Timeout and success in the same cycle resolve to success.
  - Loss-filter expiry and handshake drop in the same cycle count as one drop.

## Structure
- Shared header/package `hssl_link_ctrl_pkg`: state code localparams and the default timeout constants. `hssl_interface` users import the same sync-state encodings.
- Sub-module `hssl_sat_counter` (parameterised width, inc/clr, saturating), instantiated for `retry_cnt` and `link_drops`.
- The FSM, timer and loss filter stay inline.

## Test plan
- Clean bring-up: reset, `enable_in` = 1, sync = 00 after 5 cycles, handshake after 20 cycles → `link_reset_out` high for exactly 16 cycles; `link_up_out` = 1 and `stop_out` = 0; `retry_cnt_out` = 0.
- Sync timeout (SYNC_TIMEOUT = 32, MAX_RETRIES = 3, sync stuck at 10) → three RESET/WAIT_SYNC cycles, then `fail_out` = 1 and `state_out` = 5 with `retry_cnt_out` = 3. Deasserting `enable_in` → IDLE and `retry_cnt_out` = 0.
- Loss filter in UP: sync = 01 for 3 cycles then 00 → stays UP. Sync = 10 for 4 cycles → RESET, `link_drops_out` = 1, `stop_out` = 1 on the same edge.
- Version mismatch asserted together with `handshake_complete_in` in WAIT_HS → FAILED, `link_up_out` never asserts.
- `enable_in` dropped in UP, in the same cycle as loss-filter expiry → IDLE (not RESET), `link_drops_out` unchanged. Asynchronous `reset` pulse mid-WAIT_HS → all outputs at reset values before the next edge.
- Unlimited retries (MAX_RETRIES = 0), 300 forced timeouts → `retry_cnt_out` saturates at 255, never FAILED. `stop_req_in` = 1 in UP → `stop_out` = 1 one cycle later with `link_up_out` still 1.

Source files
------------

// File: rtl/hssl_link_ctrl_pkg.sv
// Shared definitions for the HSSL link bring-up/recovery controller:
// state codes, sync-state encodings and default timeout constants.
package hssl_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_WAIT_HS   = 3'd3,
        ST_UP        = 3'd4,
        ST_FAILED    = 3'd5
    } link_state_e;

    // Encodings of loss_of_sync_state as reported by the comma aligner
    localparam logic [1:0] SYNC_ACQUIRED = 2'b00;
    localparam logic [1:0] SYNC_RESYNC   = 2'b01;
    localparam logic [1:0] SYNC_LOST     = 2'b10;

    localparam int unsigned DEF_RESET_CYCLES = 16;
    localparam int unsigned DEF_SYNC_TIMEOUT = 65536;
    localparam int unsigned DEF_HS_TIMEOUT   = 262144;
    localparam int unsigned DEF_LOSS_FILTER  = 4;
    localparam int unsigned DEF_MAX_RETRIES  = 15;
    localparam int unsigned DEF_TIMER_BITS   = 20;

    localparam int unsigned RETRY_BITS = 8;
    localparam int unsigned DROPS_BITS = 16;

endpackage

// File: rtl/hssl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hssl_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hssl_link_ctrl.sv
// HSSL link bring-up and recovery controller: sequences reset, comma sync and
// handshake, gates traffic until UP, retries on faults and latches failure.
module hssl_link_ctrl
    import hssl_link_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int unsigned HS_TIMEOUT   = DEF_HS_TIMEOUT,
    parameter int unsigned LOSS_FILTER  = DEF_LOSS_FILTER,
    parameter int unsigned MAX_RETRIES  = DEF_MAX_RETRIES,
    parameter int unsigned TIMER_BITS   = DEF_TIMER_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_in,
    input  logic                  stop_req_in,
    input  logic [1:0]            loss_of_sync_state_in,
    input  logic                  handshake_complete_in,
    input  logic                  version_mismatch_in,
    output logic                  link_reset_out,
    output logic                  stop_out,
    output logic                  link_up_out,
    output logic                  fail_out,
    output logic [2:0]            state_out,
    output logic [RETRY_BITS-1:0] retry_cnt_out,
    output logic [DROPS_BITS-1:0] link_drops_out
);

    localparam int unsigned LOSS_BITS = (LOSS_FILTER < 2) ? 1 : $clog2(LOSS_FILTER + 1);

    link_state_e             state;
    link_state_e             next_state;
    logic [TIMER_BITS-1:0]   timer;
    logic [LOSS_BITS-1:0]    loss_cnt;
    logic [RETRY_BITS-1:0]   retry_cnt;
    logic [RETRY_BITS-1:0]   retry_inc_c;
    logic                    sync_ok_c;
    logic                    loss_hit_c;
    logic                    retry_limit_c;
    logic                    retry_c;
    logic                    drop_c;
    logic                    retry_clr_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state; retry resolution is applied last so it overrides the case result
    always_comb begin
        next_state    = state;
        retry_c       = 1'b0;
        drop_c        = 1'b0;
        sync_ok_c     = (loss_of_sync_state_in == SYNC_ACQUIRED);
        loss_hit_c    = !sync_ok_c && (loss_cnt == LOSS_BITS'(LOSS_FILTER - 1));
        retry_inc_c   = (retry_cnt == {RETRY_BITS{1'b1}}) ? retry_cnt : retry_cnt + RETRY_BITS'(1);
        retry_limit_c = (MAX_RETRIES != 0) && (32'(retry_inc_c) >= MAX_RETRIES);
        if (!enable_in) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      next_state = ST_RESET;
                ST_RESET: begin
                    if (timer == TIMER_BITS'(RESET_CYCLES - 1)) next_state = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (sync_ok_c)                                   next_state = ST_WAIT_HS;
                    else if (timer == TIMER_BITS'(SYNC_TIMEOUT - 1)) retry_c = 1'b1;
                end
                ST_WAIT_HS: begin
                    if (version_mismatch_in)                       next_state = ST_FAILED;
                    else if (!sync_ok_c)                           retry_c = 1'b1;
                    else if (handshake_complete_in)                next_state = ST_UP;
                    else if (timer == TIMER_BITS'(HS_TIMEOUT - 1)) retry_c = 1'b1;
                end
                ST_UP: begin
                    if (version_mismatch_in) begin
                        next_state = ST_FAILED;
                    end else if (loss_hit_c || !handshake_complete_in) begin
                        retry_c = 1'b1;
                        drop_c  = 1'b1;
                    end
                end
                ST_FAILED:    next_state = ST_FAILED;
                default:      next_state = ST_IDLE;
            endcase
            if (retry_c) next_state = retry_limit_c ? ST_FAILED : ST_RESET;
        end
    end

    // State timer and UP-state loss-of-sync filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            loss_cnt <= '0;
        end else begin
            timer    <= (next_state != state) ? '0 : timer + TIMER_BITS'(1);
            loss_cnt <= (next_state != ST_UP || sync_ok_c) ? '0 : loss_cnt + LOSS_BITS'(1);
        end
    end

    assign retry_clr_c = (next_state == ST_IDLE) || (next_state == ST_UP && state != ST_UP);

    hssl_sat_counter #(.WIDTH(RETRY_BITS)) u_retry_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (retry_clr_c),
        .inc   (retry_c),
        .count (retry_cnt)
    );

    hssl_sat_counter #(.WIDTH(DROPS_BITS)) u_link_drops (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (drop_c),
        .count (link_drops_out)
    );

    // Outputs decoded from next state so they move with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_reset_out <= 1'b1;
            stop_out       <= 1'b1;
            link_up_out    <= 1'b0;
            fail_out       <= 1'b0;
        end else begin
            link_reset_out <= (next_state == ST_IDLE) || (next_state == ST_RESET) ||
                              (next_state == ST_FAILED);
            stop_out       <= (next_state != ST_UP) || stop_req_in;
            link_up_out    <= (next_state == ST_UP);
            fail_out       <= (next_state == ST_FAILED);
        end
    end

    assign state_out     = state;
    assign retry_cnt_out = retry_cnt;

endmodule

// File: tb/tb_hssl_link_ctrl.sv
// Directed self-checking bench for hssl_link_ctrl: instance A (short timeouts,
// MAX_RETRIES=3) and instance B (unlimited retries, tiny timeouts).
module tb_hssl_link_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        enable_b = 1'b0;
    logic        stop_req = 1'b0;
    logic        hs = 1'b0;
    logic        vm = 1'b0;
    logic [1:0]  sync = 2'b10;

    logic        lr_a, stop_a, up_a, fail_a;
    logic [2:0]  st_a;
    logic [7:0]  rc_a;
    logic [15:0] dr_a;
    logic        lr_b, stop_b, up_b, fail_b;
    logic [2:0]  st_b;
    logic [7:0]  rc_b;
    logic [15:0] dr_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hssl_link_ctrl #(
        .RESET_CYCLES(16), .SYNC_TIMEOUT(32), .HS_TIMEOUT(64),
        .LOSS_FILTER(4), .MAX_RETRIES(3), .TIMER_BITS(8)
    ) dut_a (
        .clk(clk), .reset(reset), .enable_in(enable), .stop_req_in(stop_req),
        .loss_of_sync_state_in(sync), .handshake_complete_in(hs),
        .version_mismatch_in(vm), .link_reset_out(lr_a), .stop_out(stop_a),
        .link_up_out(up_a), .fail_out(fail_a), .state_out(st_a),
        .retry_cnt_out(rc_a), .link_drops_out(dr_a)
    );

    hssl_link_ctrl #(
        .RESET_CYCLES(2), .SYNC_TIMEOUT(4), .HS_TIMEOUT(8),
        .LOSS_FILTER(2), .MAX_RETRIES(0), .TIMER_BITS(4)
    ) dut_b (
        .clk(clk), .reset(reset), .enable_in(enable_b), .stop_req_in(stop_req),
        .loss_of_sync_state_in(sync), .handshake_complete_in(hs),
        .version_mismatch_in(vm), .link_reset_out(lr_b), .stop_out(stop_b),
        .link_up_out(up_b), .fail_out(fail_b), .state_out(st_b),
        .retry_cnt_out(rc_b), .link_drops_out(dr_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state_a(input logic [2:0] target, input int budget, input string tag,
                                output int used);
        used = 0;
        while (st_a !== target && used < budget) begin
            tick();
            used++;
        end
        check(tag, 32'(st_a), 32'(target));
    endtask

    initial begin
        int lr_cnt, up_tick, used, entries, ticks, timeouts, rc_at_100;
        logic [2:0] prev;
        logic saw_fail;

        // Reset values
        tick();
        tick();
        check("rst_state", 32'(st_a), 0);
        check("rst_link_reset", 32'(lr_a), 1);
        check("rst_stop", 32'(stop_a), 1);
        check("rst_up", 32'(up_a), 0);
        check("rst_fail", 32'(fail_a), 0);
        check("rst_retry", 32'(rc_a), 0);
        check("rst_drops", 32'(dr_a), 0);
        check("rst_b_state", 32'(st_b), 0);
        reset = 1'b0;
        tick();

        // Clean bring-up: sync after 5 cycles, handshake after 20
        enable  = 1'b1;
        lr_cnt  = 0;
        up_tick = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (lr_a) lr_cnt++;
            if (up_a && up_tick == 0) up_tick = i;
            if (i == 5)  sync = 2'b00;
            if (i == 20) hs = 1'b1;
        end
        check("bringup_reset_len", 32'(lr_cnt), 16);
        check("bringup_up_tick", 32'(up_tick), 21);
        check("bringup_up", 32'(up_a), 1);
        check("bringup_stop", 32'(stop_a), 0);
        check("bringup_state", 32'(st_a), 4);
        check("bringup_retry", 32'(rc_a), 0);

        // Loss filter: short resync burst is tolerated
        sync = 2'b01;
        repeat (3) tick();
        check("resync3_state", 32'(st_a), 4);
        sync = 2'b00;
        tick();
        check("resync_clear_state", 32'(st_a), 4);
        sync = 2'b10;
        repeat (3) tick();
        check("loss3_state", 32'(st_a), 4);
        tick();
        check("loss4_state", 32'(st_a), 1);
        check("loss4_drops", 32'(dr_a), 1);
        check("loss4_stop", 32'(stop_a), 1);
        check("loss4_up", 32'(up_a), 0);
        check("loss4_retry", 32'(rc_a), 1);

        // Recovery back to UP
        sync = 2'b00;
        wait_state_a(3'd4, 40, "recover_state", used);
        check("recover_ticks", 32'(used), 18);
        check("recover_retry", 32'(rc_a), 0);

        // stop_req reaches stop_out one cycle later
        stop_req = 1'b1;
        check("stopreq_same_cycle", 32'(stop_a), 0);
        tick();
        check("stopreq_stop", 32'(stop_a), 1);
        check("stopreq_up", 32'(up_a), 1);
        stop_req = 1'b0;
        tick();
        check("stopreq_release", 32'(stop_a), 0);

        // Enable drop coincides with loss-filter expiry
        sync = 2'b10;
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check("endrop_state", 32'(st_a), 0);
        check("endrop_drops", 32'(dr_a), 1);
        check("endrop_link_reset", 32'(lr_a), 1);

        // Version mismatch together with handshake complete in WAIT_HS
        sync   = 2'b00;
        hs     = 1'b0;
        enable = 1'b1;
        wait_state_a(3'd3, 40, "vm_reach_hs", used);
        vm = 1'b1;
        hs = 1'b1;
        tick();
        check("vm_state", 32'(st_a), 5);
        check("vm_fail", 32'(fail_a), 1);
        check("vm_up", 32'(up_a), 0);
        check("vm_link_reset", 32'(lr_a), 1);
        enable = 1'b0;
        vm     = 1'b0;
        hs     = 1'b0;
        tick();
        check("vm_exit_state", 32'(st_a), 0);
        check("vm_exit_fail", 32'(fail_a), 0);

        // Sync timeout exhausts retry budget
        sync    = 2'b10;
        enable  = 1'b1;
        entries = 0;
        ticks   = 0;
        prev    = st_a;
        while (st_a !== 3'd5 && ticks < 300) begin
            tick();
            ticks++;
            if (st_a == 3'd1 && prev != 3'd1) entries++;
            prev = st_a;
        end
        check("synct_entries", 32'(entries), 3);
        check("synct_ticks", 32'(ticks), 145);
        check("synct_state", 32'(st_a), 5);
        check("synct_fail", 32'(fail_a), 1);
        check("synct_retry", 32'(rc_a), 3);
        enable = 1'b0;
        tick();
        check("synct_idle_state", 32'(st_a), 0);
        check("synct_idle_retry", 32'(rc_a), 0);

        // Asynchronous reset in the middle of WAIT_HS
        sync   = 2'b00;
        enable = 1'b1;
        wait_state_a(3'd3, 40, "areset_reach_hs", used);
        #3 reset = 1'b1;
        #1;
        check("areset_state", 32'(st_a), 0);
        check("areset_link_reset", 32'(lr_a), 1);
        check("areset_stop", 32'(stop_a), 1);
        check("areset_fail", 32'(fail_a), 0);
        check("areset_drops", 32'(dr_a), 0);
        enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Unlimited retries: retry counter saturates, never FAILED
        sync      = 2'b10;
        enable_b  = 1'b1;
        timeouts  = 0;
        ticks     = 0;
        saw_fail  = 1'b0;
        rc_at_100 = -1;
        prev      = st_b;
        while (timeouts < 300 && ticks < 3000) begin
            tick();
            ticks++;
            if (prev == 3'd2 && st_b == 3'd1) timeouts++;
            if (timeouts == 100 && rc_at_100 < 0) rc_at_100 = int'(rc_b);
            if (fail_b) saw_fail = 1'b1;
            prev = st_b;
        end
        check("unl_timeouts", 32'(timeouts), 300);
        check("unl_retry_100", 32'(rc_at_100), 100);
        check("unl_retry_sat", 32'(rc_b), 255);
        check("unl_never_failed", 32'(saw_fail), 0);
        check("unl_state", 32'(st_b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
